// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-requester round-robin arbiter/sequencer for a shared ALU
// Optional macro ALU_ARB_ZERO_FLAG_EN adds the rsp_zero_o result flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [2*WIDTH-1:0] req_a_i,
  input  logic [2*WIDTH-1:0] req_b_i,
  input  logic [5:0]         req_op_i,
  output logic [1:0]         rsp_valid_o,
  input  logic [1:0]         rsp_ready_i,
  output logic [WIDTH-1:0]   rsp_result_o,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic               rsp_zero_o,
`endif
  output logic [WIDTH-1:0]   alu_a_o,
  output logic [WIDTH-1:0]   alu_b_o,
  output logic [2:0]         alu_op_o,
  input  logic [WIDTH-1:0]   alu_res_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant;
  logic   sel;
  logic   accept;

  // Under contention the requester that did not win last time is chosen.
  always_comb begin
    sel = 1'b0;
    if (&req_valid_i) begin
      sel = ~last_grant;
    end else if (req_valid_i[1]) begin
      sel = 1'b1;
    end
  end

  always_comb begin
    req_ready_o = 2'b00;
    if (!reset && state == IDLE && |req_valid_i) begin
      req_ready_o = sel ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid_i & req_ready_o);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_op_o     <= 3'd0;
      rsp_result_o <= '0;
      rsp_valid_o  <= 2'b00;
      busy_o       <= 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      rsp_zero_o   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a_o  <= sel ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
            alu_b_o  <= sel ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
            alu_op_o <= sel ? req_op_i[5:3] : req_op_i[2:0];
            grant    <= sel;
            busy_o   <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_o <= alu_res_i;
`ifdef ALU_ARB_ZERO_FLAG_EN
          rsp_zero_o   <= (alu_res_i == '0);
`endif
          rsp_valid_o  <= grant ? 2'b10 : 2'b01;
          state        <= RESP;
        end
        RESP: begin
          // Only the granted requester's ready can complete the response.
          if (rsp_ready_i[grant]) begin
            last_grant  <= grant;
            rsp_valid_o <= 2'b00;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_o <= 2'b00;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed self-checking bench with result scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_result;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_res;
  logic        busy;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       id;
    logic [7:0] res;
    logic       zero;
  } exp_t;

  exp_t sb[$];

  alu_arbiter #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
`ifdef ALU_ARB_ZERO_FLAG_EN
    .rsp_zero_o   (rsp_zero),
`endif
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_res_i    (alu_res),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b[2:0];
      3'd3:    return a >> b[2:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return {7'd0, a == b};
    endcase
  endfunction

  // The ALU itself lives outside the arbiter.
  always_comb alu_res = alu_model(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on request accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_rsp_id", {30'd0, rsp_valid}, e.id ? 32'd2 : 32'd1);
          check("sb_rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
`ifdef ALU_ARB_ZERO_FLAG_EN
          check("sb_rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
`endif
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (req_valid[n] && req_ready[n]) begin
          exp_t e;
          e.id   = n[0];
          e.res  = alu_model(req_a[n*8 +: 8], req_b[n*8 +: 8], req_op[n*3 +: 3]);
          e.zero = (e.res == 8'd0);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic set_req(input int n, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_a[n*8 +: 8]  = a;
    req_b[n*8 +: 8]  = b;
    req_op[n*3 +: 3] = op;
  endtask

  task automatic wait_ready(input logic [1:0] exp, input string tag);
    int n = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, {31'd0, n < 20}, 32'd1);
    check(tag, {30'd0, req_ready}, {30'd0, exp});
  endtask

  task automatic run_op(input string tag, input int id, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] exp, input logic zexp);
    @(posedge clk); #1;
    set_req(id, a, b, op);
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    rsp_ready = 2'b11;
    wait_ready(req_valid, {tag, "_grant"});
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {30'd0, rsp_valid}, (id == 1) ? 32'd2 : 32'd1);
    check({tag, "_result"}, {24'd0, rsp_result}, {24'd0, exp});
`ifdef ALU_ARB_ZERO_FLAG_EN
    check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, zexp});
`else
    if (zexp === 1'bx) check({tag, "_zero_x"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single request: 0x05 + 0x03
    @(posedge clk); #1;
    reset     = 1'b0;
    set_req(0, 8'h05, 8'h03, 3'd0);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("single_ready", {30'd0, req_ready}, 32'd1);
    check("single_busy_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("single_busy_exec", {31'd0, busy}, 32'd1);
    check("single_valid_exec", {30'd0, rsp_valid}, 32'd0);
    check("single_alu_a", {24'd0, alu_a}, 32'h05);
    check("single_alu_b", {24'd0, alu_b}, 32'h03);
    @(negedge clk);
    check("single_valid", {30'd0, rsp_valid}, 32'd1);
    check("single_result", {24'd0, rsp_result}, 32'h08);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_done_busy", {31'd0, busy}, 32'd0);
    check("single_done_valid", {30'd0, rsp_valid}, 32'd0);

    // Contention straight after reset: grants alternate starting at requester 0
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 8'h10, 8'h01, 3'd1);
    set_req(1, 8'hF0, 8'h0F, 3'd6);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ready((i % 2 == 1) ? 2'b10 : 2'b01, "cont_grant");
      @(negedge clk);
      @(negedge clk);
      check("cont_valid", {30'd0, rsp_valid}, (i % 2 == 1) ? 32'd2 : 32'd1);
      check("cont_result", {24'd0, rsp_result}, (i % 2 == 1) ? 32'hFF : 32'h0F);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;

    // Backpressure on requester 1; requester 0 waits behind it
    rsp_ready = 2'b00;
    set_req(1, 8'hAA, 8'h0F, 3'd4);
    req_valid = 2'b10;
    wait_ready(2'b10, "bp_grant");
    @(posedge clk); #1;
    set_req(0, 8'h01, 8'h01, 3'd0);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("bp_ready_exec", {30'd0, req_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {30'd0, rsp_valid}, 32'd2);
      check("bp_result", {24'd0, rsp_result}, 32'h0A);
      check("bp_ready", {30'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    wait_ready(2'b01, "bp_next");
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    run_op("add_wrap", 0, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1);
    run_op("sll",      1, 8'h81, 8'h0A, 3'd2, 8'h04, 1'b0);
    run_op("lsr",      0, 8'h80, 8'h0B, 3'd3, 8'h10, 1'b0);
    run_op("eql_hit",  1, 8'h3C, 8'h3C, 3'd7, 8'h01, 1'b0);
    run_op("eql_miss", 0, 8'h3C, 8'h3D, 3'd7, 8'h00, 1'b1);

    // Reset while a response is pending
    @(posedge clk); #1;
    set_req(0, 8'h80, 8'h01, 3'd3);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    wait_ready(2'b01, "rst_op_grant");
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst_op_valid", {30'd0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_alu_op", {29'd0, alu_op}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(1, 8'h01, 8'h02, 3'd5);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    wait_ready(2'b01, "rst_first_grant");
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one combinational 8-bit ALU between two requesters.
- Each requester presents operands and a 3-bit op code over a valid/ready request channel. The block gets a response back over a valid/ready response channel.
- Sits between client logic and the ALU instance. Drives the ALU operand/op inputs from registers and captures the ALU output into a result register.

Parameters:
- WIDTH, 8, operand/result width; must equal the ALU data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  2  per-requester request valid; bit n belongs to requester n.
- req_ready_o  output  2  per-requester request accept; one-hot or zero.
- req_a_i  input  2*WIDTH  operand A; requester n occupies bits [n*WIDTH +: WIDTH].
- req_b_i  input  2*WIDTH  operand B, same packing.
- req_op_i  input  6  op code; requester n occupies bits [n*3 +: 3]. Encoding: 0 ADD, 1 SUB, 2 SLL, 3 LSR, 4 AND, 5 OR, 6 XOR, 7 EQL.
- rsp_valid_o  output  2  per-requester response valid; one-hot or zero.
- rsp_ready_i  input  2  per-requester response accept.
- rsp_result_o  output  WIDTH  shared response data, valid for the requester flagged in rsp_valid_o.
- alu_a_o  output  WIDTH  registered operand A to the ALU.
- alu_b_o  output  WIDTH  registered operand B to the ALU.
- alu_op_o  output  3  registered op code to the ALU.
- alu_res_i  input  WIDTH  combinational ALU result.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- States: IDLE, EXEC, RESP. A 2-bit state register; all other encodings return to IDLE.
- Reset:
  - state=IDLE and last_grant=1, so requester 0 wins the first contention.
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_result_o, alu_a_o, alu_b_o, alu_op_o (=ADD), busy_o.
  - Reset in EXEC or RESP abandons the transaction; no response is ever issued for it.
- IDLE, grant selection (combinational):
  - If only one req_valid_i bit is set, that requester is granted.
  - If both are set, the requester != last_grant is granted.
  - req_ready_o[g]=1 only in IDLE and only for the granted requester. The other bit is 0.
- IDLE, on accept (req_valid_i[g] & req_ready_o[g]):
  - Capture a, b and op of requester g into alu_a_o/alu_b_o/alu_op_o.
  - Store g in grant register; next state EXEC.
- EXEC (exactly 1 cycle):
  - alu_* outputs stay stable.
  - rsp_result_o <= alu_res_i; next state RESP.
- RESP:
  - rsp_valid_o[g]=1; rsp_result_o held stable until handshake.
  - On rsp_ready_i[g]: last_grant <= g; next state IDLE.
  - rsp_ready_i of the non-granted requester is ignored.
- Latency and throughput:
  - Accept edge to rsp_valid_o high = 2 cycles.
  - Back-to-back minimum 3 cycles per operation; no new request is accepted during EXEC/RESP.
- Response backpressure: RESP holds indefinitely. req_ready_o stays 0 for both requesters throughout.
- Request channel: a request withdrawn before accept is legal; nothing is captured.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- Widths and arithmetic:
  - alu_op_o is passed through unmodified; all arithmetic is done by the ALU.
  - Results wrap modulo 2^WIDTH.
  - SLL/LSR use b[2:0] only.
  - EQL yields 1 or 0.
- alu_* outputs retain their last values in IDLE; they do not return to 0.

Optional Feature:
- Macro: ALU_ARB_ZERO_FLAG_EN.
- Defined:
  - Adds output rsp_zero_o (1 bit), registered in EXEC as (alu_res_i == 0). Valid alongside rsp_valid_o.
  - Reset value 0.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- Single request: req0 a=0x05, b=0x03, op=ADD.
  - req_ready_o=01 in the same cycle.
  - rsp_valid_o=01 two cycles after accept, rsp_result_o=0x08, busy_o high from the cycle after accept.
- Contention after reset: both valid every cycle. req0 SUB 0x10-0x01, req1 XOR 0xF0^0x0F.
  - Grant order 0,1,0,1.
  - Results alternate 0x0F, 0xFF.
- Backpressure: req1 AND 0xAA&0x0F with rsp_ready_i=00 for 5 cycles.
  - rsp_valid_o=10 and rsp_result_o=0x0A held stable.
  - req_ready_o=00 while req0 is valid.
  - Completes on rsp_ready_i=10.
- Wrap and shift: ADD 0xFF+0x01 -> 0x00 (rsp_zero_o=1 when ALU_ARB_ZERO_FLAG_EN is defined). SLL a=0x81, b=0x0A -> 0x04 (shift by 2).
- Reset mid-op: assert reset during RESP.
  - Next cycle: rsp_valid_o=00, busy_o=0, alu_op_o=0.
  - A later contention grants requester 0 first.
- EQL: a=b=0x3C -> 0x01; a=0x3C, b=0x3D -> 0x00.
